// File: rtl/word_entry.sv
// Five-letter word entry with a guessing phase: letters build the secret word, CONFIRM starts play.
// Optional build macro DUP_GUESS_FILTER_EN enables the used-letter register and dup_guess pulses.
module word_entry #(
    parameter logic [7:0] BKSP_CODE    = 8'h08,
    parameter logic [7:0] CONFIRM_CODE = 8'h0D
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    input  logic        game_rdy,
    input  logic        red_busy,
    output logic [39:0] setWord,
    output logic        toggle_state,
    output logic [7:0]  guess,
    output logic [2:0]  word_len,
    output logic        key_err,
    output logic        dup_guess
);

    typedef enum logic [1:0] {ENTRY, ARMED, START, PLAY} state_t;

    state_t      state;
    logic        key_valid_q;
    logic [7:0]  key_data_q;
    logic        game_rdy_q;
    logic        red_busy_q;

    logic [7:0]  folded;
    logic        is_letter;
    logic        is_bksp;
    logic        is_confirm;
    logic [4:0]  letter_idx;

`ifdef DUP_GUESS_FILTER_EN
    logic [25:0] used_letters;
`endif

    // Replace one byte of the word; byte 0 sits in the most significant position.
    function automatic logic [39:0] put_byte(input logic [39:0] w, input logic [2:0] idx,
                                             input logic [7:0] b);
        logic [39:0] r;
        r = w;
        for (int i = 0; i < 5; i++) begin
            if (idx == 3'(i)) r[8*(4-i) +: 8] = b;
        end
        return r;
    endfunction

    always_comb begin
        folded = key_data_q;
        if (key_data_q >= 8'h61 && key_data_q <= 8'h7A) folded = key_data_q - 8'h20;
        is_letter  = (folded >= 8'h41) && (folded <= 8'h5A);
        is_bksp    = (key_data_q == BKSP_CODE);
        is_confirm = (key_data_q == CONFIRM_CODE);
        letter_idx = 5'(folded - 8'h41);
    end

    // Keys are captured one edge and acted on the next, so every response lands at edge N+1.
    always_ff @(posedge clk) begin
        if (nRst) begin
            state        <= ENTRY;
            key_valid_q  <= 1'b0;
            key_data_q   <= 8'h00;
            game_rdy_q   <= 1'b0;
            red_busy_q   <= 1'b0;
            setWord      <= 40'h0;
            guess        <= 8'h00;
            word_len     <= 3'd0;
            toggle_state <= 1'b0;
            key_err      <= 1'b0;
`ifdef DUP_GUESS_FILTER_EN
            dup_guess    <= 1'b0;
            used_letters <= 26'h0;
`endif
        end else begin
            key_valid_q  <= key_valid;
            key_data_q   <= key_data;
            game_rdy_q   <= game_rdy;
            red_busy_q   <= red_busy;
            toggle_state <= 1'b0;
            key_err      <= 1'b0;
`ifdef DUP_GUESS_FILTER_EN
            dup_guess    <= 1'b0;
`endif
            case (state)
                ENTRY: begin
                    if (key_valid_q) begin
                        if (is_bksp) begin
                            if (word_len == 3'd0) begin
                                key_err <= 1'b1;
                            end else begin
                                setWord  <= put_byte(setWord, word_len - 3'd1, 8'h00);
                                word_len <= word_len - 3'd1;
                            end
                        end else if (is_letter) begin
                            setWord  <= put_byte(setWord, word_len, folded);
                            word_len <= word_len + 3'd1;
                            if (word_len == 3'd4) state <= ARMED;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (key_valid_q) begin
                        if (is_bksp) begin
                            setWord  <= put_byte(setWord, 3'd4, 8'h00);
                            word_len <= 3'd4;
                            state    <= ENTRY;
                        end else if (is_confirm && game_rdy_q) begin
                            toggle_state <= 1'b1;
                            state        <= START;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                START: begin
                    state <= PLAY;
                end
                PLAY: begin
                    // BKSP and CONFIRM carry no meaning once the word is locked.
                    if (key_valid_q && !is_bksp && !is_confirm) begin
                        if (!is_letter || !game_rdy_q || red_busy_q) begin
                            key_err <= 1'b1;
`ifdef DUP_GUESS_FILTER_EN
                        end else if (used_letters[letter_idx]) begin
                            dup_guess <= 1'b1;
                        end else begin
                            guess                    <= folded;
                            used_letters[letter_idx] <= 1'b1;
`else
                        end else begin
                            guess <= folded;
`endif
                        end
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

`ifndef DUP_GUESS_FILTER_EN
    assign dup_guess = 1'b0;
    logic unused_idx;
    assign unused_idx = ^letter_idx;
`endif

endmodule

// File: tb/tb_word_entry.sv
// Directed self-checking bench for word_entry; expectations follow DUP_GUESS_FILTER_EN if defined.
module tb_word_entry;

    logic        clk = 1'b0;
    logic        nRst;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        game_rdy;
    logic        red_busy;
    logic [39:0] setWord;
    logic        toggle_state;
    logic [7:0]  guess;
    logic [2:0]  word_len;
    logic        key_err;
    logic        dup_guess;

    int testCount = 0;
    int failCount = 0;

    word_entry dut (
        .clk          (clk),
        .nRst         (nRst),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .game_rdy     (game_rdy),
        .red_busy     (red_busy),
        .setWord      (setWord),
        .toggle_state (toggle_state),
        .guess        (guess),
        .word_len     (word_len),
        .key_err      (key_err),
        .dup_guess    (dup_guess)
    );

    always #5 clk = ~clk;

    // Presents one key for one cycle and returns just after the edge where its effect appears.
    task automatic applyStimulus(input logic [7:0] k);
        key_valid = 1'b1;
        key_data  = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] observed,
                               input logic [39:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        nRst = 1'b1;
        idleCycle();
        idleCycle();
        nRst = 1'b0;
    endtask

    initial begin
        nRst      = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        game_rdy  = 1'b1;
        red_busy  = 1'b0;
        doReset();

        checkOutput("rst_setWord", setWord, 40'h0);
        checkOutput("rst_word_len", 40'(word_len), 40'd0);
        checkOutput("rst_guess", 40'(guess), 40'h00);
        checkOutput("rst_toggle", 40'(toggle_state), 40'd0);
        checkOutput("rst_key_err", 40'(key_err), 40'd0);
        checkOutput("rst_dup", 40'(dup_guess), 40'd0);

        // Entry and backspace down to empty
        applyStimulus("A");
        checkOutput("A_len", 40'(word_len), 40'd1);
        applyStimulus("B");
        checkOutput("AB_len", 40'(word_len), 40'd2);
        checkOutput("AB_word", setWord, 40'h4142000000);
        applyStimulus(8'h08);
        checkOutput("bk1_len", 40'(word_len), 40'd1);
        checkOutput("bk1_word", setWord, 40'h4100000000);
        applyStimulus(8'h08);
        checkOutput("bk2_len", 40'(word_len), 40'd0);
        checkOutput("bk2_err", 40'(key_err), 40'd0);
        applyStimulus(8'h08);
        checkOutput("bk3_err", 40'(key_err), 40'd1);
        checkOutput("bk3_word", setWord, 40'h0);
        idleCycle();
        checkOutput("bk3_err_clear", 40'(key_err), 40'd0);

        applyStimulus(8'h0D);
        checkOutput("entry_confirm_err", 40'(key_err), 40'd1);
        checkOutput("entry_confirm_toggle", 40'(toggle_state), 40'd0);
        applyStimulus("1");
        checkOutput("digit_err", 40'(key_err), 40'd1);
        checkOutput("digit_len", 40'(word_len), 40'd0);

        // Full word with lowercase fold
        applyStimulus("h");
        applyStimulus("E");
        applyStimulus("L");
        applyStimulus("L");
        applyStimulus("O");
        checkOutput("hello_word", setWord, 40'h48454C4C4F);
        checkOutput("hello_len", 40'(word_len), 40'd5);
        applyStimulus("Z");
        checkOutput("full_err", 40'(key_err), 40'd1);
        checkOutput("full_word", setWord, 40'h48454C4C4F);

        game_rdy = 1'b0;
        applyStimulus(8'h0D);
        checkOutput("notrdy_err", 40'(key_err), 40'd1);
        checkOutput("notrdy_toggle", 40'(toggle_state), 40'd0);
        game_rdy = 1'b1;

        applyStimulus(8'h08);
        checkOutput("armed_bk_len", 40'(word_len), 40'd4);
        checkOutput("armed_bk_word", setWord, 40'h48454C4C00);
        applyStimulus("o");
        checkOutput("refill_word", setWord, 40'h48454C4C4F);

        applyStimulus(8'h0D);
        checkOutput("start_toggle", 40'(toggle_state), 40'd1);
        checkOutput("start_err", 40'(key_err), 40'd0);
        idleCycle();
        checkOutput("play_toggle", 40'(toggle_state), 40'd0);

        // Guessing phase
        applyStimulus("e");
        checkOutput("guess_e", 40'(guess), 40'h45);
        applyStimulus("E");
        checkOutput("repeat_guess", 40'(guess), 40'h45);
`ifdef DUP_GUESS_FILTER_EN
        checkOutput("repeat_dup", 40'(dup_guess), 40'd1);
`else
        checkOutput("repeat_dup", 40'(dup_guess), 40'd0);
`endif
        checkOutput("repeat_err", 40'(key_err), 40'd0);

        red_busy = 1'b1;
        applyStimulus("Q");
        checkOutput("busy_err", 40'(key_err), 40'd1);
        checkOutput("busy_guess", 40'(guess), 40'h45);
        red_busy = 1'b0;

        applyStimulus(8'h08);
        checkOutput("play_bk_err", 40'(key_err), 40'd0);
        checkOutput("play_bk_len", 40'(word_len), 40'd5);
        checkOutput("play_bk_word", setWord, 40'h48454C4C4F);
        applyStimulus("#");
        checkOutput("play_sym_err", 40'(key_err), 40'd1);
        applyStimulus("q");
        checkOutput("guess_q", 40'(guess), 40'h51);

        // Reset landing in the START cycle, with a key arriving alongside it
        doReset();
        applyStimulus("W");
        applyStimulus("O");
        applyStimulus("R");
        applyStimulus("D");
        applyStimulus("S");
        checkOutput("words_word", setWord, 40'h574F524453);
        applyStimulus(8'h0D);
        checkOutput("start2_toggle", 40'(toggle_state), 40'd1);
        nRst      = 1'b1;
        key_valid = 1'b1;
        key_data  = "X";
        idleCycle();
        nRst      = 1'b0;
        key_valid = 1'b0;
        key_data  = 8'h00;
        checkOutput("midstart_toggle", 40'(toggle_state), 40'd0);
        checkOutput("midstart_word", setWord, 40'h0);
        checkOutput("midstart_len", 40'(word_len), 40'd0);
        checkOutput("midstart_guess", 40'(guess), 40'h00);
        idleCycle();
        checkOutput("post_reset_len", 40'(word_len), 40'd0);
        checkOutput("post_reset_err", 40'(key_err), 40'd0);
        applyStimulus("k");
        checkOutput("post_reset_entry", setWord, 40'h4B00000000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
